// File: rtl/ife_pkg.sv
// Shared types for the Instruction Flow Expander front end: the block payload
// and the {id, payload} record held by the ingress buffer.
package ife_pkg;

    localparam int BLOCK_WORDS = 4;
    localparam int WORD_W      = 32;
    localparam int BLOCK_ID_W  = 8;

    typedef logic [BLOCK_WORDS-1:0][WORD_W-1:0] block_data_t;

    typedef struct packed {
        logic [BLOCK_ID_W-1:0] id;
        block_data_t           data;
    } block_t;

    // Downstream treats an all-zero payload as "no block", so it is never queued.
    function automatic logic is_null_block(input block_data_t d);
        return d == '0;
    endfunction

endpackage

// File: rtl/block_ingress_fifo.sv
// Ingress FWFT buffer in front of the IFE external block input; drops null blocks.
// Optional ID-sequence checker enabled by defining BLOCK_INGRESS_SEQCHK_EN.
module block_ingress_fifo
    import ife_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [BLOCK_ID_W-1:0]           in_block_id,
    input  logic [BLOCK_WORDS*WORD_W-1:0]   in_block_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [BLOCK_ID_W-1:0]           out_block_id,
    output logic [BLOCK_WORDS*WORD_W-1:0]   out_block_data,
    input  logic                            flush,
    output logic [$clog2(DEPTH):0]          count,
    output logic                            full,
    output logic                            empty,
    output logic [CNT_W-1:0]                drop_cnt,
    output logic                            seq_err
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid never waits on ready, and ready here depends only on
    // registered pointers, so out_ready has no combinational path to in_ready.

    block_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    block_t           head;

    logic accept;
    logic is_null;
    logic push;
    logic drop;
    logic pop;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;

    assign in_ready  = !full;
    assign out_valid = !empty;

    assign accept  = in_valid && in_ready;
    assign is_null = is_null_block(block_data_t'(in_block_data));
    assign push    = accept && !is_null;
    assign drop    = accept && is_null;
    assign pop     = out_valid && out_ready;

    assign head           = mem[rd_idx];
    assign out_block_id   = head.id;
    assign out_block_data = head.data;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage is deliberately not reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem[wr_idx] <= block_t'{id: in_block_id, data: block_data_t'(in_block_data)};
        end
    end

    // A null block still completes its handshake; it is only counted, never stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_ONE;
        end
    end

`ifdef BLOCK_INGRESS_SEQCHK_EN
    logic [BLOCK_ID_W-1:0] expected_id;
    logic                  seq_err_q;

    // Every accepted block counts, dropped or flushed, and the next expected ID
    // follows whatever arrived so a single gap is flagged exactly once.
    always_ff @(posedge clk) begin
        if (rst) begin
            expected_id <= '0;
            seq_err_q   <= 1'b0;
        end else if (accept) begin
            if (in_block_id != expected_id) seq_err_q <= 1'b1;
            expected_id <= in_block_id + 8'd1;
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

    a_not_full_and_empty : assert property (@(posedge clk) disable iff (rst)
        !(full && empty));

    a_out_valid_held : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=> out_valid);

endmodule

// File: doc/block_ingress_fifo.md
# block_ingress_fifo

Ingress buffer in front of the Instruction Flow Expander. Accepts externally supplied instruction blocks (8-bit ID + four 32-bit words) over a valid/ready handshake and queues them in a first-word-fall-through FIFO. Presents them one per handshake to the IFE's external block input. Drops all-zero blocks, because an all-zero payload is the "no block" sentinel downstream, and keeps occupancy and drop counters.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥ 2
- CNT_W, 16, width of the dropped-block counter

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  producer offers a block
- in_ready  out  1  FIFO can accept; equals !full
- in_block_id  in  8  block ID
- in_block_data  in  4×32 packed  block payload, word 0 = bits [31:0]
- out_valid  out  1  head entry valid for IFE
- out_ready  in  1  IFE accepts head this cycle
- out_block_id  out  8  head block ID
- out_block_data  out  4×32 packed  head block payload
- flush  in  1  discard all queued entries
- count  out  $clog2(DEPTH)+1  current occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- drop_cnt  out  CNT_W  all-zero blocks discarded since reset; saturating
- seq_err  out  1  sticky ID-sequence error (see Configuration)

## Operation
- Push condition: `in_valid && in_ready && (in_block_data != 0)` writes {id, data} at wr_ptr, then wr_ptr++.
- Drop condition: `in_valid && in_ready && (in_block_data == 0)` is accepted but not stored. drop_cnt increments and saturates at all-ones.
- Pop condition: `out_valid && out_ready` advances rd_ptr.
- out_valid = !empty. out_block_id and out_block_data always reflect the entry at rd_ptr. Contents are don't-care when empty.
- Pointers are log2(DEPTH)+1 bits wide. Indexing uses the low bits. full means MSBs differ and the low bits are equal.
- count = wr_ptr − rd_ptr, modulo 2^(log2 DEPTH + 1).
- Simultaneous push and pop while non-empty: count is unchanged and both pointers advance.
- Push while full cannot occur, because in_ready = 0. No bypass of a full FIFO, even when out_ready = 1.
- Pop while empty cannot occur, because out_valid = 0.
- flush: pointers go to 0 next cycle. A push or pop in the same cycle is ignored. drop_cnt and seq_err are kept.
- Pointer wrap-around: after DEPTH pushes the low bits return to 0 and the MSB toggles. Ordering is preserved across the wrap.

## Timing
- Reset values (next edge after rst = 1): wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, in_ready = 1, out_valid = 0, drop_cnt = 0, seq_err = 0. Memory contents are not reset.
- Latency: a block pushed at edge N gives out_valid = 1 in cycle N+1 when the FIFO was empty. Throughput is one block per cycle.
- in_ready, full, empty, count and out_valid are all derived from registered pointers. There is no combinational path from out_ready to in_ready.
- A producer must hold in_* stable while in_valid && !in_ready. The block must not drop out_valid without a pop or a flush.
- Reset mid-operation discards all entries. Behaviour matches a flush, and additionally the counters clear.

## Configuration
- BLOCK_INGRESS_SEQCHK_EN defined:
  - An 8-bit expected_id register resets to 0.
  - Every accepted block, including dropped ones, is compared against it. On mismatch, seq_err is set and stays set until rst.
  - After each accepted block, expected_id = in_block_id + 1, wrapping 255 → 0.
  - Blocks are enqueued regardless of the outcome.
- Not defined: seq_err is tied to 0 and no expected_id register exists.

## Structure
- Shared package ife_pkg holds:
  - `BLOCK_WORDS = 4`, `WORD_W = 32`, `BLOCK_ID_W = 8`
  - `typedef logic [BLOCK_WORDS-1:0][WORD_W-1:0] block_data_t`
  - `typedef struct packed {logic [BLOCK_ID_W-1:0] id; block_data_t data;} block_t`
- FIFO storage is an internal array of block_t inside block_ingress_fifo. A sub-module is not warranted, because the pointer logic and storage together stay small.

## Test plan
- After reset, push IDs 0x10..0x13 back-to-back with out_ready = 0 → count = 4. Then raise out_ready → IDs 0x10..0x13 pop in order, one per cycle, and empty = 1 after the 4th pop.
- Fill with DEPTH = 8 blocks → full = 1 and in_ready = 0. A 9th block held with in_valid = 1 is not accepted until one pop, and is then accepted on the next edge.
- Push a block with data = 0 → not stored, count is unchanged, drop_cnt = 1. Repeat for 2^CNT_W + 3 zero blocks → drop_cnt saturates at all-ones.
- With count = 3, hold in_valid = out_valid = out_ready = 1 for 20 cycles → count stays at 3, pointers wrap, and output IDs match input order.
- Assert flush with count = 5 while a push and a pop are also offered → next cycle count = 0 and empty = 1, and the pushed block never appears on the output.
- With BLOCK_INGRESS_SEQCHK_EN: push IDs 0, 1, 3 → seq_err = 1 after the third handshake and stays 1. Without the macro, the same stimulus gives seq_err = 0.
